// File: rtl/multicycle_control.sv
// Moore control FSM for the 32-bit multicycle MIPS datapath.
// Optional overflow suppression on writeback: define OVF_SUPPRESS_EN.
module multicycle_control #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       overflow,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Branch,
  output logic       BranchNE,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       ovf_trap,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       wait_done;
  logic       r_legal;
  logic [2:0] r_alu;
  logic       r_addsub;
  logic       ovf_q;

  assign wait_done = (wait_q == WAIT_MAX);
  assign state     = state_q;

  // R-type function decode: legality and ALU operation
  always_comb begin
    r_legal  = 1'b1;
    r_alu    = 3'b010;
    r_addsub = 1'b0;
    case (Funct)
      6'b100000: begin r_alu = 3'b010; r_addsub = 1'b1; end
      6'b100010: begin r_alu = 3'b110; r_addsub = 1'b1; end
      6'b100100: r_alu = 3'b000;
      6'b100101: r_alu = 3'b001;
      6'b101010: r_alu = 3'b111;
      default:   r_legal = 1'b0;
    endcase
  end

  // Next state and memory wait counter
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      FETCH: begin
        if (wait_done) state_d = DECODE;
        else           wait_d  = wait_q + 4'd1;
      end
      DECODE: begin
        case (OP)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_R:           state_d = r_legal ? EXECUTE : FETCH;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_ADDI:        state_d = ADDIEXEC;
          OP_J:           state_d = JUMP;
          default:        state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (OP == OP_SW) ? MEMWR : MEMRD;
      MEMRD: begin
        if (wait_done) state_d = MEMWB;
        else           wait_d  = wait_q + 4'd1;
      end
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
    if (state_d != state_q &&
        (state_d == FETCH || state_d == MEMRD))
      wait_d = 4'd0;
  end

  // State and wait counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef OVF_SUPPRESS_EN
  logic ovf_d;

  // Capture overflow of add/sub/addi for the following writeback
  always_comb begin
    ovf_d = 1'b0;
    if (state_q == EXECUTE)  ovf_d = overflow & r_addsub;
    if (state_q == ADDIEXEC) ovf_d = overflow;
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
`else
  logic unused_ovf;
  assign unused_ovf = overflow ^ r_addsub;
  assign ovf_q      = 1'b0;
`endif

  // Moore control decode from current state
  always_comb begin
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    BranchNE   = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = 3'b010;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    ovf_trap   = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = wait_done;
        PCWrite = wait_done;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (OP)
          OP_LW, OP_SW, OP_BEQ, OP_BNE,
          OP_ADDI, OP_J: illegal_op = 1'b0;
          OP_R:          illegal_op = ~r_legal;
          default:       illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = r_alu;
      end
      ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = ~ovf_q;
        ovf_trap   = ovf_q;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 2'b01;
        Branch     = 1'b1;
        BranchNE   = (OP == OP_BNE);
        instr_done = 1'b1;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        RegWrite   = ~ovf_q;
        ovf_trap   = ovf_q;
        instr_done = 1'b1;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: MEM_WAIT=0 and MEM_WAIT=2 instances,
// per-cycle expected state/controls queued and compared in order.
module tb_multicycle_control;

`ifdef OVF_SUPPRESS_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    bit          inst;
    logic [3:0]  st;
    logic [19:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OP = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       overflow = 1'b0;

  wire [19:0] c0, c1;
  wire [3:0]  st0, st1;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  string tname;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT(0)) u0 (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct),
    .overflow(overflow),
    .IorD(c0[19]), .ALUSrcA(c0[18]), .IRWrite(c0[17]),
    .PCWrite(c0[16]), .RegDst(c0[15]), .MemtoReg(c0[14]),
    .RegWrite(c0[13]), .MemWrite(c0[12]), .Branch(c0[11]),
    .BranchNE(c0[10]), .ALUSrcB(c0[9:8]), .PCSrc(c0[7:6]),
    .ALUControl(c0[5:3]), .instr_done(c0[2]),
    .illegal_op(c0[1]), .ovf_trap(c0[0]), .state(st0)
  );

  multicycle_control #(.MEM_WAIT(2)) u1 (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct),
    .overflow(overflow),
    .IorD(c1[19]), .ALUSrcA(c1[18]), .IRWrite(c1[17]),
    .PCWrite(c1[16]), .RegDst(c1[15]), .MemtoReg(c1[14]),
    .RegWrite(c1[13]), .MemWrite(c1[12]), .Branch(c1[11]),
    .BranchNE(c1[10]), .ALUSrcB(c1[9:8]), .PCSrc(c1[7:6]),
    .ALUControl(c1[5:3]), .instr_done(c1[2]),
    .illegal_op(c1[1]), .ovf_trap(c1[0]), .state(st1)
  );

  function automatic bit legal(input logic [5:0] op,
                               input logic [5:0] fn);
    if (op == 6'b000000)
      return fn inside {6'b100000, 6'b100010, 6'b100100,
                        6'b100101, 6'b101010};
    return op inside {6'b100011, 6'b101011, 6'b000100,
                      6'b000101, 6'b001000, 6'b000010};
  endfunction

  // Reference control table, written from the state descriptions
  function automatic logic [19:0] ctl(input int st, input bit last,
                                      input bit ovq,
                                      input logic [5:0] op,
                                      input logic [5:0] fn);
    logic iord, srca, irw, pcw, rdst, m2r, rw, mw, br, bne;
    logic done, ill, trap;
    logic [1:0] srcb, pcs;
    logic [2:0] alu;
    {iord, srca, irw, pcw, rdst, m2r, rw, mw, br, bne} = '0;
    {done, ill, trap} = '0;
    srcb = 2'b00; pcs = 2'b00; alu = 3'b010;
    case (st)
      0: begin srcb = 2'b01; irw = last; pcw = last; end
      1: begin srcb = 2'b11; ill = !legal(op, fn); end
      2: begin srca = 1; srcb = 2'b10; end
      3: iord = 1;
      4: begin m2r = 1; rw = 1; done = 1; end
      5: begin iord = 1; mw = 1; done = 1; end
      6: begin
        srca = 1;
        case (fn)
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b010;
        endcase
      end
      7: begin rdst = 1; rw = !ovq; trap = ovq; done = 1; end
      8: begin
        srca = 1; alu = 3'b110; pcs = 2'b01; br = 1;
        bne = (op == 6'b000101); done = 1;
      end
      9: begin srca = 1; srcb = 2'b10; end
      10: begin rw = !ovq; trap = ovq; done = 1; end
      11: begin pcs = 2'b10; pcw = 1; done = 1; end
      default: ;
    endcase
    return {iord, srca, irw, pcw, rdst, m2r, rw, mw, br, bne,
            srcb, pcs, alu, done, ill, trap};
  endfunction

  task automatic push(input bit inst, input int st, input bit last,
                      input bit ovq);
    exp_t e;
    e.inst = inst;
    e.st   = 4'(st);
    e.c    = ctl(st, last, ovq, OP, Funct);
    q.push_back(e);
  endtask

  // Advance one cycle, sampling the chosen DUT at the falling edge
  task automatic step(input bit inst, output logic [3:0] s,
                      output logic [19:0] c);
    @(negedge clk);
    s = inst ? st1 : st0;
    c = inst ? c1 : c0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] s;
    logic [19:0] c;
    exp_t e;
    int n;
    tname = "reset";
    OP = 6'b100011; Funct = 6'd0; overflow = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, s, c);
    checks++;
    if (s !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got %0d want 0", s);
    end
    checks++;
    if (c !== ctl(0, 1'b1, 1'b0, OP, Funct)) begin
      errors++;
      $display("FAIL reset_ctl got %h want %h", c,
               ctl(0, 1'b1, 1'b0, OP, Funct));
    end
    reset = 1'b0;
    push(0, 0, 1, 0);
    push(0, 1, 0, 0);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      e = q.pop_front();
      step(e.inst, s, c);
      checks++;
      if (s !== e.st) begin
        errors++;
        $display("FAIL %s cyc%0d state got %0d want %0d",
                 tname, i, s, e.st);
      end
      checks++;
      if (c !== e.c) begin
        errors++;
        $display("FAIL %s cyc%0d ctl got %h want %h",
                 tname, i, c, e.c);
      end
    end
  endtask

  task automatic test_lw();
    logic [3:0] s;
    logic [19:0] c;
    exp_t e;
    int n;
    tname = "lw";
    OP = 6'b100011; Funct = 6'd0; overflow = 1'b0;
    do_reset();
    push(0, 0, 1, 0); push(0, 1, 0, 0); push(0, 2, 0, 0);
    push(0, 3, 0, 0); push(0, 4, 0, 0); push(0, 0, 1, 0);
    do_reset();
    push(1, 0, 0, 0); push(1, 0, 0, 0); push(1, 0, 1, 0);
    push(1, 1, 0, 0); push(1, 2, 0, 0); push(1, 3, 0, 0);
    push(1, 3, 0, 0); push(1, 3, 0, 0); push(1, 4, 0, 0);
    push(1, 0, 0, 0);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      e = q.pop_front();
      if (i == 6) do_reset();
      step(e.inst, s, c);
      checks++;
      if (s !== e.st) begin
        errors++;
        $display("FAIL %s cyc%0d state got %0d want %0d",
                 tname, i, s, e.st);
      end
      checks++;
      if (c !== e.c) begin
        errors++;
        $display("FAIL %s cyc%0d ctl got %h want %h",
                 tname, i, c, e.c);
      end
    end
  endtask

  task automatic test_sw();
    logic [3:0] s;
    logic [19:0] c;
    exp_t e;
    int n;
    tname = "sw";
    OP = 6'b101011; Funct = 6'd0; overflow = 1'b0;
    do_reset();
    push(0, 0, 1, 0); push(0, 1, 0, 0); push(0, 2, 0, 0);
    push(0, 5, 0, 0); push(0, 0, 1, 0);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      e = q.pop_front();
      step(e.inst, s, c);
      checks++;
      if (s !== e.st) begin
        errors++;
        $display("FAIL %s cyc%0d state got %0d want %0d",
                 tname, i, s, e.st);
      end
      checks++;
      if (c !== e.c) begin
        errors++;
        $display("FAIL %s cyc%0d ctl got %h want %h",
                 tname, i, c, e.c);
      end
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0] s;
    logic [19:0] c;
    exp_t e;
    int n;
    tname = "sw_wait";
    OP = 6'b101011; Funct = 6'd0; overflow = 1'b0;
    do_reset();
    push(1, 0, 0, 0); push(1, 0, 0, 0); push(1, 0, 1, 0);
    push(1, 1, 0, 0); push(1, 2, 0, 0); push(1, 5, 0, 0);
    push(1, 0, 0, 0);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      e = q.pop_front();
      step(e.inst, s, c);
      checks++;
      if (s !== e.st) begin
        errors++;
        $display("FAIL %s cyc%0d state got %0d want %0d",
                 tname, i, s, e.st);
      end
      checks++;
      if (c !== e.c) begin
        errors++;
        $display("FAIL %s cyc%0d ctl got %h want %h",
                 tname, i, c, e.c);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] s;
    logic [19:0] c;
    exp_t e;
    int n;
    tname = "reset_mid";
    OP = 6'b101011; Funct = 6'd0; overflow = 1'b0;
    do_reset();
    push(1, 0, 0, 0); push(1, 0, 0, 0); push(1, 0, 1, 0);
    push(1, 1, 0, 0); push(1, 2, 0, 0); push(1, 0, 0, 0);
    push(1, 0, 0, 0); push(1, 0, 1, 0); push(1, 1, 0, 0);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      e = q.pop_front();
      reset = (i == 4);
      step(e.inst, s, c);
      checks++;
      if (s !== e.st) begin
        errors++;
        $display("FAIL %s cyc%0d state got %0d want %0d",
                 tname, i, s, e.st);
      end
      checks++;
      if (c !== e.c) begin
        errors++;
        $display("FAIL %s cyc%0d ctl got %h want %h",
                 tname, i, c, e.c);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    logic [3:0] s;
    logic [19:0] c;
    logic [5:0] fns [5];
    exp_t e;
    int n;
    bit ovq;
    fns = '{6'b101010, 6'b100000, 6'b100010,
            6'b100100, 6'b100101};
    tname = "rtype";
    OP = 6'b000000;
    for (int k = 0; k < 5; k++) begin
      Funct = fns[k];
      overflow = (k != 0);
      ovq = OVF_EN && overflow &&
            (Funct == 6'b100000 || Funct == 6'b100010);
      do_reset();
      push(0, 0, 1, 0); push(0, 1, 0, 0); push(0, 6, 0, 0);
      push(0, 7, 0, ovq); push(0, 0, 1, 0);
      n = q.size();
      for (int i = 0; i < n; i++) begin
        e = q.pop_front();
        step(e.inst, s, c);
        checks++;
        if (s !== e.st) begin
          errors++;
          $display("FAIL %s f%0d cyc%0d state got %0d want %0d",
                   tname, k, i, s, e.st);
        end
        checks++;
        if (c !== e.c) begin
          errors++;
          $display("FAIL %s f%0d cyc%0d ctl got %h want %h",
                   tname, k, i, c, e.c);
        end
      end
    end
    overflow = 1'b0;
  endtask

  task automatic test_illegal();
    logic [3:0] s;
    logic [19:0] c;
    exp_t e;
    int n;
    tname = "illegal";
    OP = 6'b000000; Funct = 6'b111111; overflow = 1'b0;
    do_reset();
    push(0, 0, 1, 0); push(0, 1, 0, 0); push(0, 0, 1, 0);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      e = q.pop_front();
      if (i == 2) OP = 6'b111111;
      step(e.inst, s, c);
      checks++;
      if (s !== e.st) begin
        errors++;
        $display("FAIL %s cyc%0d state got %0d want %0d",
                 tname, i, s, e.st);
      end
      checks++;
      if (c !== e.c) begin
        errors++;
        $display("FAIL %s cyc%0d ctl got %h want %h",
                 tname, i, c, e.c);
      end
    end
    push(0, 1, 0, 0); push(0, 0, 1, 0);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      e = q.pop_front();
      step(e.inst, s, c);
      checks++;
      if (s !== e.st) begin
        errors++;
        $display("FAIL %s op cyc%0d state got %0d want %0d",
                 tname, i, s, e.st);
      end
      checks++;
      if (c !== e.c) begin
        errors++;
        $display("FAIL %s op cyc%0d ctl got %h want %h",
                 tname, i, c, e.c);
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [3:0] s;
    logic [19:0] c;
    logic [5:0] ops [3];
    exp_t e;
    int n;
    ops = '{6'b000101, 6'b000100, 6'b000010};
    tname = "branch_jump";
    Funct = 6'd0; overflow = 1'b0;
    for (int k = 0; k < 3; k++) begin
      OP = ops[k];
      do_reset();
      push(0, 0, 1, 0); push(0, 1, 0, 0);
      push(0, (k == 2) ? 11 : 8, 0, 0); push(0, 0, 1, 0);
      n = q.size();
      for (int i = 0; i < n; i++) begin
        e = q.pop_front();
        step(e.inst, s, c);
        checks++;
        if (s !== e.st) begin
          errors++;
          $display("FAIL %s op%0d cyc%0d state got %0d want %0d",
                   tname, k, i, s, e.st);
        end
        checks++;
        if (c !== e.c) begin
          errors++;
          $display("FAIL %s op%0d cyc%0d ctl got %h want %h",
                   tname, k, i, c, e.c);
        end
      end
    end
  endtask

  task automatic test_addi_ovf();
    logic [3:0] s;
    logic [19:0] c;
    exp_t e;
    int n;
    tname = "addi_ovf";
    OP = 6'b001000; Funct = 6'd0;
    for (int k = 0; k < 2; k++) begin
      overflow = (k == 1);
      do_reset();
      push(0, 0, 1, 0); push(0, 1, 0, 0); push(0, 9, 0, 0);
      push(0, 10, 0, OVF_EN && overflow); push(0, 0, 1, 0);
      n = q.size();
      for (int i = 0; i < n; i++) begin
        e = q.pop_front();
        step(e.inst, s, c);
        checks++;
        if (s !== e.st) begin
          errors++;
          $display("FAIL %s ov%0d cyc%0d state got %0d want %0d",
                   tname, k, i, s, e.st);
        end
        checks++;
        if (c !== e.c) begin
          errors++;
          $display("FAIL %s ov%0d cyc%0d ctl got %h want %h",
                   tname, k, i, c, e.c);
        end
      end
    end
    overflow = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_sw_wait();
    test_reset_mid();
    test_rtype();
    test_illegal();
    test_branch_jump();
    test_addi_ovf();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
